// File: rtl/uart_mmio_pkg.sv
// Shared register map, STATUS bit positions and serial FSM states for uart_mmio.
package uart_mmio_pkg;

  localparam logic [1:0] OFF_TXDATA = 2'd0;
  localparam logic [1:0] OFF_RXDATA = 2'd1;
  localparam logic [1:0] OFF_STATUS = 2'd2;
  localparam logic [1:0] OFF_RSVD   = 2'd3;

  localparam int unsigned ST_TX_FULL   = 0;
  localparam int unsigned ST_TX_EMPTY  = 1;
  localparam int unsigned ST_RX_VALID  = 2;
  localparam int unsigned ST_RX_OVR    = 3;
  localparam int unsigned ST_RX_FERR   = 4;
  localparam int unsigned ST_TX_DROP   = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

endpackage

// File: rtl/uart_mmio_if.sv
// CPU byte bus as seen by a memory-mapped peripheral.
interface uart_mmio_if;
  logic [15:0] addr;
  logic        we;
  logic        rd;
  logic [7:0]  din;
  logic [7:0]  dout;
  logic        hit;

  modport master (output addr, we, rd, din, input dout, hit);
  modport slave  (input addr, we, rd, din, output dout, hit);
endinterface

// File: rtl/uart_mmio_sync_fifo.sv
// Synchronous first-word-fall-through FIFO; push and pop may coincide.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok, pop_ok;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign rdata = mem_q[rd_ptr_q];

  // Pointer and occupancy update; a push into a full FIFO is ignored.
  always_comb begin
    push_ok  = push && !full;
    pop_ok   = pop && !empty;
    wr_ptr_d = wr_ptr_q + AW'(push_ok);
    rd_ptr_d = rd_ptr_q + AW'(pop_ok);
    count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
  end

  // Control registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array, no reset needed.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/uart_mmio.sv
// Memory-mapped 8N1 UART: 4-byte register window, TX FIFO, single RX holding byte.
module uart_mmio
  import uart_mmio_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR    = 16'd992,
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned TX_DEPTH     = 8
) (
  input  logic       clk,
  input  logic       rst,
  uart_mmio_if.slave bus,
  output logic       uart_tx,
  input  logic       uart_rx
);

  localparam int unsigned BW        = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BAUD_HALF = BW'(CLKS_PER_BIT / 2 - 1);

  // Bus side
  logic [15:0] off_full;
  logic [1:0]  off;
  logic        in_win, push, rd_rx, rd_st;
  logic [7:0]  status, dout_q, dout_d;
  logic        hit_q, hit_d;
  logic        rx_valid_q, rx_valid_d, rx_ovr_q, rx_ovr_d;
  logic        rx_ferr_q, rx_ferr_d, tx_drop_q, tx_drop_d;
  logic [7:0]  rx_data_q, rx_data_d;

  // TX side
  uart_state_t tx_state_q, tx_state_d;
  logic [BW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]  tx_bit_q, tx_bit_d;
  logic [7:0]  tx_shift_q, tx_shift_d;
  logic        tx_q, tx_d, tx_empty;
  logic        fifo_pop, fifo_full, fifo_empty;
  logic [7:0]  fifo_rdata;

  // RX side
  uart_state_t rx_state_q, rx_state_d;
  logic [BW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic [7:0]  rx_shift_q, rx_shift_d;
  logic        rx_s1_q, rx_s2_q, rx_prev_q;
  logic        rx_load, rx_ferr;

  sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (fifo_pop),
    .wdata (bus.din),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign bus.dout = dout_q;
  assign bus.hit  = hit_q;
  assign uart_tx  = tx_q;

  // Address decode, read mux and status flag updates (a new event wins over a same-cycle clear).
  always_comb begin
    off_full = bus.addr - BASE_ADDR;
    in_win   = (off_full < 16'd4);
    off      = off_full[1:0];
    push     = bus.we && in_win && (off == OFF_TXDATA);
    rd_rx    = bus.rd && in_win && (off == OFF_RXDATA);
    rd_st    = bus.rd && in_win && (off == OFF_STATUS);
    tx_empty = fifo_empty && (tx_state_q == IDLE);

    status              = '0;
    status[ST_TX_FULL]  = fifo_full;
    status[ST_TX_EMPTY] = tx_empty;
    status[ST_RX_VALID] = rx_valid_q;
    status[ST_RX_OVR]   = rx_ovr_q;
    status[ST_RX_FERR]  = rx_ferr_q;
    status[ST_TX_DROP]  = tx_drop_q;

    hit_d  = in_win;
    dout_d = '0;
    if (in_win) begin
      case (off)
        OFF_RXDATA: dout_d = rx_data_q;
        OFF_STATUS: dout_d = status;
        default:    dout_d = '0;
      endcase
    end

    rx_data_d  = rx_load ? rx_shift_q : rx_data_q;
    rx_valid_d = (rx_valid_q && !rd_rx) || rx_load;
    rx_ovr_d   = (rx_ovr_q && !rd_st) || (rx_load && rx_valid_q && !rd_rx);
    rx_ferr_d  = (rx_ferr_q && !rd_st) || rx_ferr;
    tx_drop_d  = (tx_drop_q && !rd_st) || (push && fifo_full);
  end

  // TX FSM: line value is registered alongside the state it belongs to.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q + 1'b1;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_d       = 1'b1;
    fifo_pop   = 1'b0;
    case (tx_state_q)
      IDLE: begin
        tx_cnt_d = '0;
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          tx_shift_d = fifo_rdata;
          tx_state_d = START;
          tx_d       = 1'b0;
        end
      end
      START: begin
        tx_d = 1'b0;
        if (tx_cnt_q == BAUD_LAST) begin
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_state_d = DATA;
          tx_d       = tx_shift_q[0];
        end
      end
      DATA: begin
        tx_d = tx_shift_q[0];
        if (tx_cnt_q == BAUD_LAST) begin
          tx_cnt_d = '0;
          if (tx_bit_q == 3'd7) begin
            tx_state_d = STOP;
            tx_d       = 1'b1;
          end else begin
            tx_bit_d   = tx_bit_q + 1'b1;
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
            tx_d       = tx_shift_q[1];
          end
        end
      end
      STOP: begin
        if (tx_cnt_q == BAUD_LAST) begin
          tx_cnt_d = '0;
          if (!fifo_empty) begin
            fifo_pop   = 1'b1;
            tx_shift_d = fifo_rdata;
            tx_state_d = START;
            tx_d       = 1'b0;
          end else begin
            tx_state_d = IDLE;
          end
        end
      end
      default: tx_state_d = IDLE;
    endcase
  end

  // RX FSM: start validated at mid-bit, data sampled at bit centres, leaves half a stop bit early.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q + 1'b1;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_load    = 1'b0;
    rx_ferr    = 1'b0;
    case (rx_state_q)
      IDLE: begin
        rx_cnt_d = '0;
        if (rx_prev_q && !rx_s2_q) rx_state_d = START;
      end
      START: begin
        if (rx_cnt_q == BAUD_HALF) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_s2_q ? IDLE : DATA;
        end
      end
      DATA: begin
        if (rx_cnt_q == BAUD_LAST) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
          rx_bit_d   = rx_bit_q + 1'b1;
          if (rx_bit_q == 3'd7) rx_state_d = STOP;
        end
      end
      STOP: begin
        if (rx_cnt_q == BAUD_LAST) begin
          rx_cnt_d   = '0;
          rx_state_d = IDLE;
          rx_load    = rx_s2_q;
          rx_ferr    = !rx_s2_q;
        end
      end
      default: rx_state_d = IDLE;
    endcase
  end

  // All block state, synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout_q     <= '0;
      hit_q      <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_ovr_q   <= 1'b0;
      rx_ferr_q  <= 1'b0;
      tx_drop_q  <= 1'b0;
      rx_data_q  <= '0;
      tx_state_q <= IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_q       <= 1'b1;
      rx_state_q <= IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
    end else begin
      dout_q     <= dout_d;
      hit_q      <= hit_d;
      rx_valid_q <= rx_valid_d;
      rx_ovr_q   <= rx_ovr_d;
      rx_ferr_q  <= rx_ferr_d;
      tx_drop_q  <= tx_drop_d;
      rx_data_q  <= rx_data_d;
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_q       <= tx_d;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_s1_q    <= uart_rx;
      rx_s2_q    <= rx_s1_q;
      rx_prev_q  <= rx_s2_q;
    end
  end

endmodule

// File: tb/tb_uart_mmio.sv
// Self-checking bench for uart_mmio: bus decode, TX framing/FIFO, RX status flags, reset.
module tb_uart_mmio;

  localparam int unsigned CPB   = 4;
  localparam int unsigned DEPTH = 8;
  localparam logic [15:0] A_TX  = 16'd992;
  localparam logic [15:0] A_RX  = 16'd993;
  localparam logic [15:0] A_ST  = 16'd994;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic uart_tx;
  logic uart_rx = 1'b1;

  uart_mmio_if bus ();

  uart_mmio #(
    .BASE_ADDR    (16'd992),
    .CLKS_PER_BIT (CPB),
    .TX_DEPTH     (DEPTH)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .uart_tx (uart_tx),
    .uart_rx (uart_rx)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int rst_cnt     = 0;
  logic [7:0] tx_got [$];

  // Reference model of the software-visible RX/TX flags.
  bit m_valid, m_ovr, m_ferr, m_drop;
  logic [7:0] m_rxdata = 8'h00;

  always @(posedge clk) if (rst) rst_cnt <= rst_cnt + 1;

  function automatic logic [7:0] exp_status(input bit full, input bit empty);
    return {2'b00, m_drop, m_ferr, m_ovr, m_valid, empty, full};
  endfunction

  // Serial decoder for uart_tx: samples mid-bit, discards frames interrupted by reset.
  initial begin : tx_monitor
    logic [7:0] b;
    int rc0;
    bit ok;
    forever begin
      @(negedge clk);
      if (!rst && uart_tx === 1'b0) begin
        rc0 = rst_cnt;
        ok  = 1'b1;
        repeat (CPB / 2) @(negedge clk);
        if (uart_tx !== 1'b0) ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          b[i] = uart_tx;
        end
        repeat (CPB) @(negedge clk);
        if (ok && rc0 == rst_cnt && !rst) begin
          vectors++;
          if (uart_tx !== 1'b1) begin
            miscompares++;
            $display("FAIL tx_stop_bit: line=%b required 1", uart_tx);
          end
          tx_got.push_back(b);
        end
      end
    end
  end

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    bus.addr = a; bus.din = d; bus.we = 1'b1;
    @(negedge clk);
    bus.we = 1'b0;
  endtask

  task automatic rd_bus(input logic [15:0] a, input logic r, output logic [7:0] d, output logic h);
    bus.addr = a; bus.rd = r;
    @(negedge clk);
    bus.rd = 1'b0;
    d = bus.dout;
    h = bus.hit;
  endtask

  task automatic send_rx(input logic [7:0] b, input bit stop_bit);
    uart_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    uart_rx = stop_bit;
    repeat (CPB) @(negedge clk);
    uart_rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    if (stop_bit) begin
      if (m_valid) m_ovr = 1'b1;
      m_valid  = 1'b1;
      m_rxdata = b;
    end else begin
      m_ferr = 1'b1;
    end
  endtask

  task automatic wait_frames(input int n, input int limit);
    int k = 0;
    while (tx_got.size() < n && k < limit) begin
      @(negedge clk);
      k++;
    end
    vectors++;
    if (tx_got.size() != n) begin
      miscompares++;
      $display("FAIL tx_frame_count: got %0d frames required %0d", tx_got.size(), n);
    end
  endtask

  task automatic test_reset;
    logic [7:0] d; logic h;
    bus.addr = A_ST; bus.we = 1'b0; bus.rd = 1'b0; bus.din = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if (uart_tx !== 1'b1) begin miscompares++; $display("FAIL reset_tx: got %b required 1", uart_tx); end
    vectors++;
    if (bus.hit !== 1'b0 || bus.dout !== 8'h00) begin
      miscompares++; $display("FAIL reset_bus: hit=%b dout=%h required 0/00", bus.hit, bus.dout);
    end
    rst = 1'b0;
    rd_bus(A_ST, 1'b1, d, h);
    vectors++;
    if (d !== exp_status(0, 1) || h !== 1'b1) begin
      miscompares++; $display("FAIL reset_status: got %h/%b required %h/1", d, h, exp_status(0, 1));
    end
  endtask

  task automatic test_decode;
    logic [15:0] addrs [8];
    logic [7:0] d, ed; logic h, eh;
    addrs = '{16'd991, 16'd992, 16'd993, 16'd994, 16'd995, 16'd996, 16'd0, 16'hFFFF};
    for (int i = 0; i < 8; i++) begin
      rd_bus(addrs[i], 1'b0, d, h);
      eh = (addrs[i] >= 16'd992) && (addrs[i] <= 16'd995);
      ed = (addrs[i] == 16'd993) ? m_rxdata : (addrs[i] == 16'd994) ? exp_status(0, 1) : 8'h00;
      vectors++;
      if (d !== ed || h !== eh) begin
        miscompares++;
        $display("FAIL decode_%0d: dout=%h hit=%b required %h/%b", addrs[i], d, h, ed, eh);
      end
    end
    wr(16'd991, 8'hAB); wr(16'd993, 8'hCD); wr(16'd994, 8'hEF); wr(16'd995, 8'h12); wr(16'd996, 8'h34);
    repeat (3) @(negedge clk);
    rd_bus(A_ST, 1'b1, d, h);
    vectors++;
    if (d !== exp_status(0, 1) || uart_tx !== 1'b1) begin
      miscompares++; $display("FAIL decode_nopush: status=%h tx=%b required %h/1", d, uart_tx, exp_status(0, 1));
    end
  endtask

  task automatic test_tx_pattern;
    logic [9:0] frame;
    logic [7:0] d; logic h;
    int k;
    frame = {1'b1, 8'h55, 1'b0};
    wr(A_TX, 8'h55);
    rd_bus(A_ST, 1'b1, d, h);
    vectors++;
    if (d !== exp_status(0, 0)) begin
      miscompares++; $display("FAIL tx_busy_status: got %h required %h", d, exp_status(0, 0));
    end
    k = 0;
    while (uart_tx !== 1'b0 && k < 10) begin @(negedge clk); k++; end
    vectors++;
    if (k >= 10) begin miscompares++; $display("FAIL tx_start_timeout: line=%b required 0", uart_tx); end
    for (int i = 0; i < 10 * CPB; i++) begin
      vectors++;
      if (uart_tx !== frame[i / CPB]) begin
        miscompares++; $display("FAIL tx_wave_cycle%0d: got %b required %b", i, uart_tx, frame[i / CPB]);
      end
      @(negedge clk);
    end
    rd_bus(A_ST, 1'b1, d, h);
    vectors++;
    if (d !== exp_status(0, 1)) begin
      miscompares++; $display("FAIL tx_done_status: got %h required %h", d, exp_status(0, 1));
    end
    wait_frames(1, 20);
    if (tx_got.size() > 0) begin
      d = tx_got.pop_front();
      vectors++;
      if (d !== 8'h55) begin miscompares++; $display("FAIL tx_decoded: got %h required 55", d); end
    end
  endtask

  // Ten back-to-back stores: one goes straight to the shifter, DEPTH fill the FIFO, the last is dropped.
  task automatic test_back_to_back;
    logic [7:0] sent [$];
    logic [7:0] d; logic h;
    int n;
    n = DEPTH + 2;
    for (int i = 0; i < n; i++) sent.push_back(8'($urandom));
    for (int i = 0; i < n; i++) wr(A_TX, sent[i]);
    m_drop = 1'b1;
    rd_bus(A_ST, 1'b1, d, h);
    vectors++;
    if (d !== exp_status(1, 0)) begin
      miscompares++; $display("FAIL burst_status: got %h required %h", d, exp_status(1, 0));
    end
    m_drop = 1'b0;
    rd_bus(A_ST, 1'b1, d, h);
    vectors++;
    if (d !== exp_status(1, 0)) begin
      miscompares++; $display("FAIL burst_drop_clear: got %h required %h", d, exp_status(1, 0));
    end
    wait_frames(DEPTH + 1, 12 * CPB * (DEPTH + 2));
    for (int i = 0; i < DEPTH + 1; i++) begin
      if (tx_got.size() > 0) begin
        d = tx_got.pop_front();
        vectors++;
        if (d !== sent[i]) begin miscompares++; $display("FAIL burst_frame%0d: got %h required %h", i, d, sent[i]); end
      end
    end
    repeat (3 * CPB) @(negedge clk);
    rd_bus(A_ST, 1'b0, d, h);
    vectors++;
    if (d !== exp_status(0, 1) || tx_got.size() != 0) begin
      miscompares++; $display("FAIL burst_drained: status=%h extra=%0d required %h/0", d, tx_got.size(), exp_status(0, 1));
    end
  endtask

  task automatic test_rx_basic;
    logic [7:0] d, b; logic h;
    for (int it = 0; it < 2; it++) begin
      b = (it == 0) ? 8'hA3 : 8'($urandom);
      send_rx(b, 1'b1);
      rd_bus(A_ST, 1'b1, d, h);
      vectors++;
      if (d !== exp_status(0, 1)) begin miscompares++; $display("FAIL rx_status_valid: got %h required %h", d, exp_status(0, 1)); end
      rd_bus(A_RX, 1'b0, d, h);
      rd_bus(A_ST, 1'b0, d, h);
      vectors++;
      if (d !== exp_status(0, 1)) begin miscompares++; $display("FAIL rx_peek_nopop: got %h required %h", d, exp_status(0, 1)); end
      rd_bus(A_RX, 1'b1, d, h);
      vectors++;
      if (d !== m_rxdata) begin miscompares++; $display("FAIL rx_data: got %h required %h", d, m_rxdata); end
      m_valid = 1'b0;
      rd_bus(A_ST, 1'b1, d, h);
      vectors++;
      if (d !== exp_status(0, 1)) begin miscompares++; $display("FAIL rx_status_popped: got %h required %h", d, exp_status(0, 1)); end
    end
  endtask

  task automatic test_rx_overrun;
    logic [7:0] d; logic h;
    send_rx(8'($urandom), 1'b1);
    send_rx(8'($urandom), 1'b1);
    rd_bus(A_RX, 1'b0, d, h);
    vectors++;
    if (d !== m_rxdata) begin miscompares++; $display("FAIL ovr_data: got %h required %h", d, m_rxdata); end
    rd_bus(A_ST, 1'b1, d, h);
    vectors++;
    if (d !== exp_status(0, 1)) begin miscompares++; $display("FAIL ovr_status: got %h required %h", d, exp_status(0, 1)); end
    m_ovr = 1'b0;
    rd_bus(A_ST, 1'b1, d, h);
    vectors++;
    if (d !== exp_status(0, 1)) begin miscompares++; $display("FAIL ovr_cleared: got %h required %h", d, exp_status(0, 1)); end
    rd_bus(A_RX, 1'b1, d, h);
    m_valid = 1'b0;
  endtask

  task automatic test_rx_errors;
    logic [7:0] d; logic h;
    send_rx(8'($urandom), 1'b0);
    rd_bus(A_ST, 1'b1, d, h);
    vectors++;
    if (d !== exp_status(0, 1)) begin miscompares++; $display("FAIL ferr_status: got %h required %h", d, exp_status(0, 1)); end
    m_ferr = 1'b0;
    rd_bus(A_ST, 1'b0, d, h);
    vectors++;
    if (d !== exp_status(0, 1)) begin miscompares++; $display("FAIL ferr_cleared: got %h required %h", d, exp_status(0, 1)); end
    uart_rx = 1'b0;
    @(negedge clk);
    uart_rx = 1'b1;
    repeat (20) @(negedge clk);
    rd_bus(A_ST, 1'b1, d, h);
    vectors++;
    if (d !== exp_status(0, 1)) begin miscompares++; $display("FAIL glitch_status: got %h required %h", d, exp_status(0, 1)); end
    send_rx(8'($urandom), 1'b1);
    rd_bus(A_RX, 1'b1, d, h);
    vectors++;
    if (d !== m_rxdata) begin miscompares++; $display("FAIL post_glitch_data: got %h required %h", d, m_rxdata); end
    m_valid = 1'b0;
  endtask

  task automatic test_random_traffic;
    logic [7:0] b, d; logic h;
    for (int it = 0; it < 3; it++) begin
      b = 8'($urandom);
      wr(A_TX, b);
      wait_frames(1, 16 * CPB);
      if (tx_got.size() > 0) begin
        d = tx_got.pop_front();
        vectors++;
        if (d !== b) begin miscompares++; $display("FAIL rand_tx%0d: got %h required %h", it, d, b); end
      end
      repeat (CPB) @(negedge clk);
      send_rx(8'($urandom), 1'b1);
      rd_bus(A_RX, 1'b1, d, h);
      vectors++;
      if (d !== m_rxdata || h !== 1'b1) begin miscompares++; $display("FAIL rand_rx%0d: got %h required %h", it, d, m_rxdata); end
      m_valid = 1'b0;
    end
  endtask

  task automatic test_reset_mid_tx;
    logic [7:0] d; logic h;
    int lows;
    for (int i = 0; i < 4; i++) wr(A_TX, 8'($urandom));
    repeat (12) @(negedge clk);
    bus.addr = A_ST;
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if (uart_tx !== 1'b1 || bus.hit !== 1'b0 || bus.dout !== 8'h00) begin
      miscompares++; $display("FAIL midtx_reset: tx=%b hit=%b dout=%h required 1/0/00", uart_tx, bus.hit, bus.dout);
    end
    rst = 1'b0;
    m_valid = 0; m_ovr = 0; m_ferr = 0; m_drop = 0;
    rd_bus(A_ST, 1'b1, d, h);
    vectors++;
    if (d !== exp_status(0, 1)) begin miscompares++; $display("FAIL midtx_status: got %h required %h", d, exp_status(0, 1)); end
    lows = 0;
    for (int i = 0; i < 60 * CPB; i++) begin
      if (uart_tx !== 1'b1) lows++;
      @(negedge clk);
    end
    vectors++;
    if (lows != 0 || tx_got.size() != 0) begin
      miscompares++; $display("FAIL midtx_silent: low cycles=%0d frames=%0d required 0/0", lows, tx_got.size());
    end
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
    $fatal(1);
  end

  initial begin : main
    test_reset();
    test_decode();
    test_tx_pattern();
    test_back_to_back();
    test_rx_basic();
    test_rx_overrun();
    test_rx_errors();
    test_random_traffic();
    test_reset_mid_tx();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
